round_sequencer: RTL and testbench

- Game-round controller for the color-matcher.
- Sequences each round: load a new target colour, show it, run the round countdown, judge the player's submission, then hold the result.
- Drives the enable and clear of the seconds timer and the target-colour generator's load strobe.
- Keeps the round count and score for the HEX/LED display logic.

---
 rtl/round_sequencer.sv | 169 ++++++++++++++++
 tb/tb_round_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// Game-round controller for the color-matcher: load/show/play/result/done sequencing,
// round countdown, score keeping. Optional pause input under `ifdef ROUND_PAUSE_EN.
module round_sequencer #(
    parameter int CLKS_PER_TICK = 50,
    parameter int ROUND_TIME    = 9,
    parameter int SHOW_TIME     = 2,
    parameter int RESULT_TIME   = 2,
    parameter int NUM_ROUNDS    = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       submit,
    input  logic       match,
`ifdef ROUND_PAUSE_EN
    input  logic       pause,
`endif
    output logic       target_load,
    output logic       timer_en,
    output logic       timer_clr_n,
    output logic [3:0] time_left,
    output logic [2:0] round_num,
    output logic [7:0] score,
    output logic       hit,
    output logic       game_over,
    output logic [2:0] state
);

    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SHOW   = 3'd2,
        S_PLAY   = 3'd3,
        S_RESULT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      phase_q, phase_d;
    logic [3:0]      time_left_q, time_left_d;
    logic [2:0]      round_q, round_d;
    logic [7:0]      score_q, score_d;
    logic            hit_q, hit_d;
    logic            timer_en_q, timer_en_d;
    logic            paused;
    logic            active;
    logic            tick;
    logic [8:0]      score_sum;

    always_comb begin
`ifdef ROUND_PAUSE_EN
        paused = pause;
`else
        paused = 1'b0;
`endif
        active    = (state_q == S_SHOW) || (state_q == S_PLAY) || (state_q == S_RESULT);
        tick      = active && !paused && (cnt_q == CW'(CLKS_PER_TICK - 1));
        score_sum = {1'b0, score_q} + 9'(time_left_q) + 9'd1;

        state_d     = state_q;
        time_left_d = time_left_q;
        round_d     = round_q;
        score_d     = score_q;
        hit_d       = hit_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    round_d     = '0;
                    score_d     = '0;
                    hit_d       = 1'b0;
                    time_left_d = 4'(ROUND_TIME);
                end
            end
            S_LOAD: state_d = S_SHOW;
            S_SHOW: begin
                if (tick && phase_q == 4'(SHOW_TIME - 1))
                    state_d = S_PLAY;
            end
            S_PLAY: begin
                // A submit on the final tick wins and keeps the pre-decrement time for scoring
                if (submit && !paused) begin
                    hit_d   = match;
                    if (match)
                        score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
                    state_d = S_RESULT;
                end else if (tick) begin
                    time_left_d = time_left_q - 4'd1;
                    if (time_left_q == 4'd1) begin
                        hit_d   = 1'b0;
                        state_d = S_RESULT;
                    end
                end
            end
            S_RESULT: begin
                if (tick && phase_q == 4'(RESULT_TIME - 1)) begin
                    if (round_q == 3'(NUM_ROUNDS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        round_d     = round_q + 3'd1;
                        time_left_d = 4'(ROUND_TIME);
                        state_d     = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (state_d != state_q) begin
            cnt_d   = '0;
            phase_d = '0;
        end else if (active && !paused) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
            if (tick && state_q != S_PLAY)
                phase_d = phase_q + 4'd1;
        end

        // Entering IDLE (only via an unused code) restores the reset picture
        if (state_d == S_IDLE) begin
            time_left_d = '0;
            round_d     = '0;
            score_d     = '0;
            hit_d       = 1'b0;
        end

        timer_en_d = (state_d == S_PLAY) && !paused;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            phase_q     <= '0;
            time_left_q <= '0;
            round_q     <= '0;
            score_q     <= '0;
            hit_q       <= 1'b0;
            timer_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            time_left_q <= time_left_d;
            round_q     <= round_d;
            score_q     <= score_d;
            hit_q       <= hit_d;
            timer_en_q  <= timer_en_d;
        end
    end

    always_comb begin
        target_load = (state_q == S_LOAD);
        timer_clr_n = (state_q != S_IDLE) && (state_q != S_LOAD);
        game_over   = (state_q == S_DONE);
        timer_en    = timer_en_q;
        time_left   = time_left_q;
        round_num   = round_q;
        score       = score_q;
        hit         = hit_q;
        state       = state_q;
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with a small game configuration.
// Covers the ROUND_PAUSE_EN variant when that macro is defined.
module tb_round_sequencer;

    logic       clk = 1'b0;
    logic       resetn, start, submit, match;
`ifdef ROUND_PAUSE_EN
    logic       pause;
`endif
    logic       target_load, timer_en, timer_clr_n, hit, game_over;
    logic [3:0] time_left;
    logic [2:0] round_num, state;
    logic [7:0] score;

    int n_checks = 0;
    int n_fail   = 0;

    round_sequencer #(
        .CLKS_PER_TICK(4),
        .ROUND_TIME   (3),
        .SHOW_TIME    (1),
        .RESULT_TIME  (1),
        .NUM_ROUNDS   (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .submit     (submit),
        .match      (match),
`ifdef ROUND_PAUSE_EN
        .pause      (pause),
`endif
        .target_load(target_load),
        .timer_en   (timer_en),
        .timer_clr_n(timer_clr_n),
        .time_left  (time_left),
        .round_num  (round_num),
        .score      (score),
        .hit        (hit),
        .game_over  (game_over),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; start = 1'b0; submit = 1'b0; match = 1'b0;
`ifdef ROUND_PAUSE_EN
        pause = 1'b0;
`endif
        step(2);
        chk("rst_state", 32'(state), 0);
        chk("rst_target_load", 32'(target_load), 0);
        chk("rst_timer_clr_n", 32'(timer_clr_n), 0);
        chk("rst_timer_en", 32'(timer_en), 0);
        chk("rst_time_left", 32'(time_left), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_game_over", 32'(game_over), 0);
        resetn = 1'b1;
        step(1);
        chk("idle_hold", 32'(state), 0);

        // Round 0: basic sequencing and hit scoring
        start = 1'b1; step(1); start = 1'b0;
        chk("load_state", 32'(state), 1);
        chk("load_target_load", 32'(target_load), 1);
        chk("load_timer_clr_n", 32'(timer_clr_n), 0);
        chk("load_time_left", 32'(time_left), 3);
        step(1);
        chk("show_state", 32'(state), 2);
        chk("show_target_load", 32'(target_load), 0);
        chk("show_timer_clr_n", 32'(timer_clr_n), 1);
        chk("show_timer_en", 32'(timer_en), 0);
        submit = 1'b1; match = 1'b1; step(1); submit = 1'b0; match = 1'b0;
        chk("show_submit_ignored", 32'(state), 2);
        step(2);
        chk("show_4th_cycle", 32'(state), 2);
        step(1);
        chk("play_state", 32'(state), 3);
        chk("play_timer_en", 32'(timer_en), 1);
        chk("play_time_left", 32'(time_left), 3);
        start = 1'b1; step(1); start = 1'b0;
        chk("play_start_ignored", 32'(state), 3);
        submit = 1'b1; match = 1'b1; step(1); submit = 1'b0; match = 1'b0;
        chk("hit_state", 32'(state), 4);
        chk("hit_flag", 32'(hit), 1);
        chk("hit_score", 32'(score), 4);
        chk("result_timer_en", 32'(timer_en), 0);
        step(3);
        chk("result_4th_cycle", 32'(state), 4);
        step(1);
        chk("load2_state", 32'(state), 1);
        chk("load2_round", 32'(round_num), 1);
        chk("load2_target_load", 32'(target_load), 1);
        chk("load2_time_left", 32'(time_left), 3);

        // Round 1: submit coincides with the final tick
        step(5);
        chk("play2_state", 32'(state), 3);
        step(3);
        chk("play2_tl3", 32'(time_left), 3);
        step(1);
        chk("play2_tl2", 32'(time_left), 2);
        step(4);
        chk("play2_tl1", 32'(time_left), 1);
        step(3);
        submit = 1'b1; match = 1'b1; step(1); submit = 1'b0; match = 1'b0;
        chk("tie_state", 32'(state), 4);
        chk("tie_score", 32'(score), 6);
        chk("tie_time_left", 32'(time_left), 1);
        chk("tie_hit", 32'(hit), 1);
        step(4);
        chk("done_state", 32'(state), 5);
        chk("done_game_over", 32'(game_over), 1);
        chk("done_score", 32'(score), 6);
        chk("done_round", 32'(round_num), 1);
        chk("done_hit", 32'(hit), 1);
        step(2);
        chk("done_hold", 32'(state), 5);

        // Restart from DONE, then a timeout round
        start = 1'b1; step(1); start = 1'b0;
        chk("restart_state", 32'(state), 1);
        chk("restart_score", 32'(score), 0);
        chk("restart_round", 32'(round_num), 0);
        chk("restart_hit", 32'(hit), 0);
        chk("restart_game_over", 32'(game_over), 0);
        step(5);
        chk("to_play", 32'(state), 3);
        step(4);
        chk("to_tl2", 32'(time_left), 2);
        step(4);
        chk("to_tl1", 32'(time_left), 1);
        step(4);
        chk("to_tl0", 32'(time_left), 0);
        chk("to_state", 32'(state), 4);
        chk("to_hit", 32'(hit), 0);
        chk("to_score", 32'(score), 0);
        step(4);
        chk("to_next_load", 32'(state), 1);
        chk("to_next_round", 32'(round_num), 1);

        // Reset in the middle of PLAY
        step(5);
        chk("rp_play", 32'(state), 3);
        step(2);
        resetn = 1'b0; step(1); resetn = 1'b1;
        chk("rp_state", 32'(state), 0);
        chk("rp_timer_en", 32'(timer_en), 0);
        chk("rp_score", 32'(score), 0);
        chk("rp_time_left", 32'(time_left), 0);
        chk("rp_round", 32'(round_num), 0);
        chk("rp_target_load", 32'(target_load), 0);
        step(1);
        chk("rp_idle_hold", 32'(state), 0);
        chk("rp_no_load", 32'(target_load), 0);

        // New game, miss scoring (and pause when built in)
        start = 1'b1; step(1); start = 1'b0;
        step(5);
        chk("miss_play", 32'(state), 3);
`ifdef ROUND_PAUSE_EN
        pause = 1'b1;
        step(1);
        chk("pause_timer_en", 32'(timer_en), 0);
        submit = 1'b1; match = 1'b1; step(1); submit = 1'b0; match = 1'b0;
        chk("pause_submit_ignored", 32'(state), 3);
        step(8);
        pause = 1'b0;
        step(1);
        chk("pause_released_en", 32'(timer_en), 1);
        step(2);
        chk("pause_tl3", 32'(time_left), 3);
        step(1);
        chk("pause_tl2", 32'(time_left), 2);
`endif
        submit = 1'b1; match = 1'b0; step(1); submit = 1'b0;
        chk("miss_state", 32'(state), 4);
        chk("miss_hit", 32'(hit), 0);
        chk("miss_score", 32'(score), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
